// File: rtl/calibration_sequencer.sv
// calibration_sequencer
// Front-end controller for the frequency calibrator datapath. A job is
// started with `start`. The block then loads a stream of signed 20-bit
// deltas into the shared calibration list memory and runs the calibrator
// twice. The first run is a single pass that yields the final sum. The
// second run is a repeat pass that yields the first repeated frequency.
// The repeat pass is guarded by a cycle timeout, which aborts the
// calibrator through cal_rst.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   start               begin a job (honoured only in IDLE)
//   freq_initial        signed starting frequency, sampled on start
//   in_valid/in_ready/in_data/in_last
//                       delta stream handshake
//   mem_we/mem_addr/mem_wdata
//                       registered list memory write port
//   cal_rst             calibrator reset (RST or timeout abort)
//   cal_enable          one-cycle start pulse to the calibrator
//   cal_ready           calibrator idle flag
//   cal_re_iterate      calibrator mode (0 single pass, 1 repeat pass)
//   cal_freq_initial    initial frequency driven to the calibrator
//   cal_list_length     number of valid list entries
//   cal_result          calibrator result
//   part1, part2        captured single-pass / repeat-pass results
//   busy, done          job status, done is a one-cycle pulse
//   error               0 ok, 1 list overflow, 2 repeat timeout
module calibration_sequencer #(
  parameter int MAX_LEN        = 1023,
  parameter int TIMEOUT_CYCLES = 16777216,
  parameter int TO_W           = 25
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic signed [19:0] freq_initial,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [19:0] in_data,
  input  logic               in_last,
  output logic               mem_we,
  output logic [9:0]         mem_addr,
  output logic signed [19:0] mem_wdata,
  output logic               cal_rst,
  output logic               cal_enable,
  input  logic               cal_ready,
  output logic               cal_re_iterate,
  output logic signed [19:0] cal_freq_initial,
  output logic [9:0]         cal_list_length,
  input  logic signed [19:0] cal_result,
  output logic signed [19:0] part1,
  output logic signed [19:0] part2,
  output logic               busy,
  output logic               done,
  output logic [1:0]         error
);

  localparam logic [9:0]      MAX_L   = 10'(MAX_LEN);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, P1_GO, P1_BUSY, P1_WAIT, P2_GO, P2_BUSY, P2_WAIT, ABORT, FIN
  } state_t;

  state_t          state;
  logic [9:0]      count;
  logic [TO_W-1:0] to_cnt;
  logic            abort_p0;

  // The abort pulse is a register that is high only during the ABORT state.
  // The calibrator therefore sees a clean single-cycle reset. The reset
  // input itself reaches the calibrator directly.
  assign cal_rst = RST | abort_p0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= IDLE;
      count            <= '0;
      to_cnt           <= '0;
      abort_p0         <= 1'b0;
      in_ready         <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      cal_enable       <= 1'b0;
      cal_re_iterate   <= 1'b0;
      cal_freq_initial <= '0;
      cal_list_length  <= '0;
      part1            <= '0;
      part2            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 2'd0;
    end else begin
      mem_we     <= 1'b0;
      cal_enable <= 1'b0;
      done       <= 1'b0;
      abort_p0   <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            cal_freq_initial <= freq_initial;
            error            <= 2'd0;
            count            <= '0;
            in_ready         <= (MAX_L != 10'd0);
            busy             <= 1'b1;
            state            <= LOAD;
          end
        end

        // In this state in_ready always equals (count != MAX_L). A beat
        // that arrives while the list is full is refused, and the job ends
        // with an overflow error.
        LOAD: begin
          if (in_valid) begin
            if (count == MAX_L) begin
              error    <= 2'd1;
              in_ready <= 1'b0;
              state    <= FIN;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= count;
              mem_wdata <= in_data;
              count     <= count + 10'd1;
              if (in_last) begin
                cal_list_length <= count + 10'd1;
                cal_re_iterate  <= 1'b0;
                in_ready        <= 1'b0;
                state           <= P1_GO;
              end else begin
                in_ready <= ((count + 10'd1) != MAX_L);
              end
            end
          end
        end

        // The mode is already stable here, so the enable pulse arrives at
        // least one cycle after it. The enable pulse also follows the last
        // list write.
        P1_GO: begin
          if (cal_ready) begin
            cal_enable <= 1'b1;
            state      <= P1_BUSY;
          end
        end

        P1_BUSY: begin
          if (!cal_ready) state <= P1_WAIT;
        end

        P1_WAIT: begin
          if (cal_ready) begin
            part1          <= cal_result;
            cal_re_iterate <= 1'b1;
            to_cnt         <= '0;
            state          <= P2_GO;
          end
        end

        // Repeat pass: to_cnt counts the cycles spent across P2_GO, P2_BUSY
        // and P2_WAIT. The ABORT state is entered after exactly
        // TIMEOUT_CYCLES of these cycles.
        P2_GO: begin
          if (to_cnt == TO_LAST) begin
            abort_p0 <= 1'b1;
            state    <= ABORT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            if (cal_ready) begin
              cal_enable <= 1'b1;
              state      <= P2_BUSY;
            end
          end
        end

        P2_BUSY: begin
          if (to_cnt == TO_LAST) begin
            abort_p0 <= 1'b1;
            state    <= ABORT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            if (!cal_ready) state <= P2_WAIT;
          end
        end

        // The result capture is checked first. A result that arrives in the
        // same cycle as the timeout expiry is kept, and no error is raised.
        P2_WAIT: begin
          if (cal_ready) begin
            part2 <= cal_result;
            state <= FIN;
          end else if (to_cnt == TO_LAST) begin
            abort_p0 <= 1'b1;
            state    <= ABORT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        ABORT: begin
          error <= 2'd2;
          state <= FIN;
        end

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calibration_sequencer.sv
module tb_calibration_sequencer;

  logic               CLK;
  logic               RST;
  logic               start;
  logic signed [19:0] freq_initial;
  logic               in_valid;
  logic               in_ready;
  logic signed [19:0] in_data;
  logic               in_last;
  logic               mem_we;
  logic [9:0]         mem_addr;
  logic signed [19:0] mem_wdata;
  logic               cal_rst;
  logic               cal_enable;
  logic               cal_ready;
  logic               cal_re_iterate;
  logic signed [19:0] cal_freq_initial;
  logic [9:0]         cal_list_length;
  logic signed [19:0] cal_result;
  logic signed [19:0] part1;
  logic signed [19:0] part2;
  logic               busy;
  logic               done;
  logic [1:0]         error;

  calibration_sequencer #(
    .MAX_LEN       (1023),
    .TIMEOUT_CYCLES(50),
    .TO_W          (25)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .start           (start),
    .freq_initial    (freq_initial),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_last         (in_last),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .cal_rst         (cal_rst),
    .cal_enable      (cal_enable),
    .cal_ready       (cal_ready),
    .cal_re_iterate  (cal_re_iterate),
    .cal_freq_initial(cal_freq_initial),
    .cal_list_length (cal_list_length),
    .cal_result      (cal_result),
    .part1           (part1),
    .part2           (part2),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // List memory image, filled from the DUT write port.
  logic signed [19:0] lmem [0:1023];

  // Behavioural calibrator. cal_ready drops on the cycle after enable. The
  // result appears a few cycles later. If a repeat pass finds no repeated
  // frequency, the model hangs until cal_rst.
  function automatic logic signed [19:0] cal_model(input logic rep, input int len,
                                                   input logic signed [19:0] f0,
                                                   output bit found);
    logic signed [19:0] f;
    logic signed [19:0] seen[$];
    f = f0;
    found = 1'b0;
    if (len == 0) return '0;
    if (!rep) begin
      for (int i = 0; i < len; i++) f = f + lmem[i];
      found = 1'b1;
      return f;
    end
    seen.push_back(f);
    for (int s = 0; s < 3000; s++) begin
      f = f + lmem[s % len];
      foreach (seen[j]) if (seen[j] == f) begin
        found = 1'b1;
        return f;
      end
      seen.push_back(f);
    end
    return '0;
  endfunction

  logic               c_ready;
  logic signed [19:0] c_res = '0;
  logic signed [19:0] c_pend;
  int                 c_cnt;
  bit                 c_hang;
  logic signed [19:0] m_r;
  bit                 m_found;

  assign cal_ready  = c_ready;
  assign cal_result = c_res;

  always @(posedge CLK) begin
    if (cal_rst) begin
      c_ready <= 1'b1;
      c_cnt   <= 0;
      c_hang  <= 1'b0;
    end else if (c_ready) begin
      if (cal_enable) begin
        m_r = cal_model(cal_re_iterate, int'(cal_list_length), cal_freq_initial, m_found);
        c_pend  <= m_r;
        c_ready <= 1'b0;
        c_hang  <= !m_found;
        c_cnt   <= 4;
      end
    end else if (!c_hang) begin
      if (c_cnt <= 1) begin
        c_ready <= 1'b1;
        c_res   <= c_pend;
      end else begin
        c_cnt <= c_cnt - 1;
      end
    end
  end

  // Monitors sample on the falling edge.
  int   cyc = 0, wr_cnt = 0, done_cnt = 0, en_cnt = 0, en_bad = 0;
  int   en_p1 = 0, en_p2 = 0, ri_bad = 0, rstp_cnt = 0;
  int   p2go_cyc = 0, abort_cyc = 0, last_addr = -1;
  logic mode_at_en = 1'b0;
  logic ri_prev = 1'b0;

  always @(negedge CLK) begin
    cyc++;
    if (mem_we === 1'b1) begin
      lmem[mem_addr] = mem_wdata;
      wr_cnt++;
      last_addr = int'(mem_addr);
    end
    if (done === 1'b1) done_cnt++;
    if (cal_enable === 1'b1) begin
      en_cnt++;
      if (!cal_ready) en_bad++;
      if (cal_re_iterate) en_p2++;
      else en_p1++;
      mode_at_en = cal_re_iterate;
    end else if (cal_ready === 1'b0 && RST === 1'b0 && cal_re_iterate !== mode_at_en) begin
      ri_bad++;
    end
    if (cal_re_iterate === 1'b1 && ri_prev === 1'b0) p2go_cyc = cyc;
    ri_prev = cal_re_iterate;
    if (cal_rst === 1'b1 && RST === 1'b0) begin
      rstp_cnt++;
      abort_cyc = cyc;
    end
  end

  task automatic start_job(input logic signed [19:0] f0);
    @(posedge CLK); #1;
    start = 1'b1;
    freq_initial = f0;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic send_list(input int vals[$], input bit toggle, input string tag);
    int  i = 0;
    int  c = 0;
    bit  ph = 1'b0;
    bit  acc;
    while (i < vals.size() && c < 200) begin
      if (toggle && ph) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = vals[i];
        in_last  = (i == vals.size() - 1);
      end
      acc = in_valid && in_ready;
      @(posedge CLK); #1;
      c++;
      ph = ~ph;
      if (acc) i++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_val({tag, "_beats"}, i, vals.size());
  endtask

  task automatic wait_done(input int bound, input string tag);
    int c = 0;
    while (done !== 1'b1 && c < bound) begin
      @(negedge CLK);
      c++;
    end
    check_val({tag, "_done"}, int'(done === 1'b1), 1);
    repeat (3) @(negedge CLK);
  endtask

  int q[$];
  int wr0, dn0, en0, rp0, c;

  initial begin
    RST = 1'b1;
    start = 1'b0;
    freq_initial = '0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_cal_rst", cal_rst, 1);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_error", error, 0);
    check_val("rst_part1", part1, 0);
    check_val("rst_len", cal_list_length, 0);
    RST = 1'b0;
    #1;
    check_val("rst_cal_rst_low", cal_rst, 0);

    // Job 1: +1,-2,+3,+1 gives a sum of 3 and a first repeat of 2.
    wr0 = wr_cnt; dn0 = done_cnt;
    start_job(20'sd0);
    check_val("j1_busy", busy, 1);
    q = '{1, -2, 3, 1};
    send_list(q, 1'b0, "j1");
    wait_done(200, "j1");
    check_val("j1_writes", wr_cnt - wr0, 4);
    check_val("j1_last_addr", last_addr, 3);
    check_val("j1_mem1", lmem[1], -2);
    check_val("j1_mem3", lmem[3], 1);
    check_val("j1_len", cal_list_length, 4);
    check_val("j1_part1", part1, 3);
    check_val("j1_part2", part2, 2);
    check_val("j1_error", error, 0);
    check_val("j1_done_pulses", done_cnt - dn0, 1);
    check_val("j1_busy_end", busy, 0);

    // Job 2: +3,+3,+4,-2,-4 gives a sum of 4 and a first repeat of 10.
    en0 = en_p1 + 2 * en_p2;
    dn0 = done_cnt;
    start_job(20'sd0);
    q = '{3, 3, 4, -2, -4};
    send_list(q, 1'b0, "j2");
    wait_done(200, "j2");
    check_val("j2_part1", part1, 4);
    check_val("j2_part2", part2, 10);
    check_val("j2_modes", en_p1 + 2 * en_p2 - en0, 3);
    check_val("j2_mode_stable", ri_bad, 0);
    check_val("j2_done_pulses", done_cnt - dn0, 1);

    // Job 3: -6,+3,+8,+5,-6 with in_valid toggling gives 4 and 5.
    wr0 = wr_cnt;
    start_job(20'sd0);
    q = '{-6, 3, 8, 5, -6};
    send_list(q, 1'b1, "j3");
    wait_done(200, "j3");
    check_val("j3_writes", wr_cnt - wr0, 5);
    check_val("j3_mem2", lmem[2], 8);
    check_val("j3_part1", part1, 4);
    check_val("j3_part2", part2, 5);
    check_val("j3_error", error, 0);

    // Job 4: 1024 beats with no last beat. The list overflows after 1023.
    wr0 = wr_cnt; en0 = en_cnt; dn0 = done_cnt;
    start_job(20'sd0);
    for (int i = 0; i < 1023; i++) begin
      in_valid = 1'b1;
      in_data  = 20'(i);
      in_last  = 1'b0;
      @(posedge CLK); #1;
    end
    check_val("j4_ready_full", in_ready, 0);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    wait_done(50, "j4");
    check_val("j4_writes", wr_cnt - wr0, 1023);
    check_val("j4_last_addr", last_addr, 1022);
    check_val("j4_error", error, 1);
    check_val("j4_no_enable", en_cnt - en0, 0);
    check_val("j4_done_pulses", done_cnt - dn0, 1);
    check_val("j4_part2_held", part2, 5);

    // Job 5: +1,+1 never repeats, so the repeat pass times out after 50 cycles.
    rp0 = rstp_cnt;
    start_job(20'sd0);
    q = '{1, 1};
    send_list(q, 1'b0, "j5");
    wait_done(300, "j5");
    check_val("j5_part1", part1, 2);
    check_val("j5_error", error, 2);
    check_val("j5_part2_held", part2, 5);
    check_val("j5_abort_width", rstp_cnt - rp0, 1);
    check_val("j5_abort_delay", abort_cyc - p2go_cyc, 50);
    check_val("j5_enable_ok", en_bad, 0);

    // Job 6: reset during P1_WAIT, then a clean +7,-7 job.
    start_job(20'sd0);
    q = '{1, -2, 3, 1};
    send_list(q, 1'b0, "j6a");
    c = 0;
    while (cal_ready !== 1'b0 && c < 50) begin
      @(negedge CLK);
      c++;
    end
    check_val("j6_cal_started", int'(cal_ready === 1'b0), 1);
    @(negedge CLK);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check_val("j6_rst_busy", busy, 0);
    check_val("j6_rst_part1", part1, 0);
    check_val("j6_rst_cal_rst", cal_rst, 1);
    RST = 1'b0;
    dn0 = done_cnt;
    start_job(20'sd0);
    q = '{7, -7};
    send_list(q, 1'b0, "j6b");
    wait_done(200, "j6b");
    check_val("j6_len", cal_list_length, 2);
    check_val("j6_part1", part1, 0);
    check_val("j6_part2", part2, 0);
    check_val("j6_error", error, 0);
    check_val("j6_done_pulses", done_cnt - dn0, 1);
    check_val("j6_mode_stable", ri_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calibration_sequencer.md
Name: calibration_sequencer

Overview:
- Front-end controller for the frequency calibrator datapath.
- Accepts a stream of signed 20-bit calibration deltas and writes them into the shared calibration list memory.
- Then runs the calibrator twice: first a single pass (re_iterate=0, final sum), then a repeat pass (re_iterate=1, first repeated frequency).
- Captures both results and guards the repeat pass with a cycle timeout that aborts the calibrator via its reset.

Parameters:
- MAX_LEN, 1023, maximum list entries accepted (list length port is 10 bits).
- TIMEOUT_CYCLES, 16777216, maximum cycles the repeat pass may stay busy before abort.
- TO_W, 25, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- start  in  1  begin a load+run job; honoured only in IDLE
- freq_initial  in  20  signed starting frequency; sampled on start
- in_valid  in  1  delta stream valid
- in_ready  out  1  delta stream ready
- in_data  in  20  signed delta
- in_last  in  1  marks final delta of the list
- mem_we  out  1  list memory write strobe
- mem_addr  out  10  list memory write address
- mem_wdata  out  20  list memory write data
- cal_rst  out  1  calibrator reset; asserted on RST and on timeout abort
- cal_enable  out  1  calibrator enable pulse
- cal_ready  in  1  calibrator idle flag
- cal_re_iterate  out  1  calibrator mode
- cal_freq_initial  out  20  signed initial frequency to calibrator
- cal_list_length  out  10  number of valid list entries
- cal_result  in  20  signed calibrator result
- part1  out  20  signed single-pass result
- part2  out  20  signed first repeated frequency
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a job ends (success or error)
- error  out  2  0 ok, 1 list overflow, 2 repeat timeout; held until next start

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cal_enable=0, cal_re_iterate=0, cal_freq_initial=0, cal_list_length=0, part1=0, part2=0, busy=0, done=0, error=0, internal counters 0.
- cal_rst is high whenever RST is high.
- Reset mid-job: the job is abandoned and the block returns to IDLE. Memory contents and results are not preserved.
- States: IDLE, LOAD, P1_GO, P1_BUSY, P1_WAIT, P2_GO, P2_BUSY, P2_WAIT, ABORT, FIN.
- IDLE:
  - On start: latch freq_initial into cal_freq_initial, clear error and the length counter, go to LOAD.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1. Each beat with in_valid&in_ready produces a registered memory write one cycle later: mem_we=1, mem_addr=count, mem_wdata=in_data. The counter then increments.
  - Beat with in_last: accept and write it, set cal_list_length=count+1, go to P1_GO.
  - If a beat arrives while count==MAX_LEN: do not accept it (in_ready=0 when count==MAX_LEN), set error=1, go to FIN.
  - The block never presents an empty list: length is always >=1.
- Px_GO:
  - Set cal_re_iterate (0 for P1, 1 for P2) one cycle before the enable pulse.
  - Pulse cal_enable for exactly one cycle, only while cal_ready=1, then go to Px_BUSY.
  - cal_re_iterate is held stable from Px_GO until the result is captured.
- Px_BUSY: wait for cal_ready=0, which the calibrator guarantees on the cycle after enable. Then go to Px_WAIT.
- Px_WAIT: on cal_ready=1, capture cal_result into part1 or part2 in that cycle. P1 proceeds to P2_GO; P2 proceeds to FIN.
- Timeout:
  - The counter runs from P2_GO through P2_WAIT.
  - On reaching TIMEOUT_CYCLES: go to ABORT, which asserts cal_rst for exactly 1 cycle. Then set error=2 and go to FIN; part2 is left unchanged.
  - The P1 pass always terminates and is not timed.
- FIN: pulse done for 1 cycle, drop busy, return to IDLE. part1, part2 and error hold until the next start.
- Simultaneous cal_ready rise and timeout expiry in P2_WAIT: the result capture wins, and there is no error.
- Arithmetic: widths are fixed at 20 bits signed, with no saturation or extension. Results pass through unchanged.
- Latency from last beat to done = 2 cycles + P1 calc cycles + P2 calc cycles + handshake cycles (~3 per pass).

Test Plan:
- Deltas +1,-2,+3,+1 (last on 4th), freq_initial=0 -> 4 writes to addr 0..3, cal_list_length=4, part1=3, part2=2, error=0, single done pulse.
- Deltas +3,+3,+4,-2,-4, freq_initial=0 -> part1=4, part2=10; cal_re_iterate=0 throughout P1 and 1 throughout P2.
- Deltas -6,+3,+8,+5,-6 with in_valid toggling every other cycle -> writes only on handshakes, part1=4, part2=5.
- Stream of 1024 beats without last, MAX_LEN=1023 -> 1023 writes, in_ready low on 1024th, error=1, done pulse, calibrator never enabled.
- Deltas +1,+1 with TIMEOUT_CYCLES=50 -> part1=2, cal_rst pulses 1 cycle ~50 cycles after P2_GO, error=2, part2 unchanged.
- RST asserted during P1_WAIT, then new start with +7,-7 -> clean restart, part1=0, part2=0 after the new job.
